// File: rtl/seven_seg_pkg.sv
// Shared segment encodings and leading-zero helper for the seven-segment display blocks.
// Segment words are active-low with bit 6 = a down to bit 0 = g.
package seven_seg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h7F;

  localparam seg_t SEG_HEX [16] = '{
    7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
    7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
  };

  // Bit k is set when digit k (k >= 1) and every more-significant digit are zero.
  function automatic logic [7:0] lz_mask(input logic [31:0] digits, input int n);
    logic zero_run;
    lz_mask  = '0;
    zero_run = 1'b1;
    for (int k = 7; k >= 1; k--) begin
      if (k < n) begin
        zero_run   = zero_run & (digits[4*k +: 4] == 4'h0);
        lz_mask[k] = zero_run;
      end
    end
  endfunction

endpackage

// File: rtl/seven_seg_hex_decode.sv
// Combinational 4-bit hex to active-low seven-segment decoder.
// Also usable on its own by single-digit displays.
module seven_seg_hex_decode
  import seven_seg_pkg::*;
(
  input  logic [3:0] hex,
  output seg_t       seg_n
);

  assign seg_n = SEG_HEX[hex];

endmodule

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed scanner for common-anode seven-segment digits with frame-coherent
// shadow registers, per-digit blanking/decimal points and leading-zero suppression.
module seven_segment_scanner
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int LZ_BLANK    = 1,
  localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable_i,
  input  logic [4*NUM_DIGITS-1:0] digits_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic [NUM_DIGITS-1:0]   blank_i,
  output logic [6:0]              seg_n,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic [IDX_W-1:0]        digit_idx
);

  localparam int               PRE_W    = $clog2(REFRESH_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [PRE_W-1:0]        prescaler;
  logic                    started;
  logic [4*NUM_DIGITS-1:0] digits_sh;
  logic [NUM_DIGITS-1:0]   dp_sh;
  logic [NUM_DIGITS-1:0]   blank_sh;

  logic                    tick;
  logic                    capture;
  logic [IDX_W-1:0]        idx_next;
  logic [4*NUM_DIGITS-1:0] digits_cur;
  logic [NUM_DIGITS-1:0]   dp_cur;
  logic [NUM_DIGITS-1:0]   blank_cur;
  int                      sel;
  logic [3:0]              hex_sel;
  seg_t                    seg_dec;
  logic [7:0]              lz;
  seg_t                    seg_nx;
  logic                    dp_nx;

  assign tick    = enable_i && (prescaler == PRE_LAST);
  assign capture = enable_i && (!started || (tick && (digit_idx == IDX_LAST)));

  always_comb begin
    idx_next = digit_idx;
    if (tick) begin
      idx_next = (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
    end
  end

  // The output registers are loaded from the post-edge shadow values so that the
  // wrap edge already shows freshly captured data on digit 0.
  assign digits_cur = capture ? digits_i : digits_sh;
  assign dp_cur     = capture ? dp_i     : dp_sh;
  assign blank_cur  = capture ? blank_i  : blank_sh;

  assign sel     = int'(idx_next);
  assign hex_sel = digits_cur[4*sel +: 4];
  assign lz      = lz_mask(32'(digits_cur), NUM_DIGITS);

  seven_seg_hex_decode u_decode (
    .hex   (hex_sel),
    .seg_n (seg_dec)
  );

  always_comb begin
    seg_nx = seg_dec;
    dp_nx  = ~dp_cur[sel];
    if (blank_cur[sel]) begin
      seg_nx = SEG_BLANK;
      dp_nx  = 1'b1;
    end else if ((LZ_BLANK != 0) && lz[sel]) begin
      seg_nx = SEG_BLANK;
    end
  end

  // Anodes go dark for one cycle on every digit change to avoid ghosting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler <= '0;
      digit_idx <= '0;
      started   <= 1'b0;
      digits_sh <= '0;
      dp_sh     <= '0;
      blank_sh  <= '0;
      an_n      <= '1;
      seg_n     <= SEG_BLANK;
      dp_n      <= 1'b1;
    end else if (!enable_i) begin
      an_n  <= '1;
      seg_n <= SEG_BLANK;
      dp_n  <= 1'b1;
    end else begin
      started   <= 1'b1;
      prescaler <= tick ? '0 : prescaler + 1'b1;
      digit_idx <= idx_next;
      if (capture) begin
        digits_sh <= digits_i;
        dp_sh     <= dp_i;
        blank_sh  <= blank_i;
      end
      seg_n <= seg_nx;
      dp_n  <= dp_nx;
      an_n  <= (tick || !started) ? '1 : ~(NUM_DIGITS'(1) << digit_idx);
    end
  end

endmodule
